// File: rtl/axis_nway_adder_pkg.sv
// Shared constants and helper functions for the stream-adder blocks.
// Provides a constant clog2 and the full-precision sum width used by the adder.
package axis_nway_adder_pkg;

  localparam int MIN_CH = 2;
  localparam int MAX_CH = 16;

  // Constant-evaluable ceil(log2(value)); clog2_f(1) = 0.
  function automatic int clog2_f(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // Width that holds the exact sum of num_ch operands of data_w bits.
  function automatic int sum_w_f(input int data_w, input int num_ch);
    return data_w + clog2_f(num_ch);
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with a valid/ready write port and a show-ahead read port.
// Pointers carry one extra wrap bit so full and empty are distinguished without a counter.
module axis_sync_fifo
  import axis_nway_adder_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              empty_o
);

  localparam int AW = clog2_f(DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              open_q;
  logic              full;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);

  // Ready comes only from registered state; open_q holds it low until the first edge after reset.
  assign wr_ready_o = open_q & ~full;
  assign push       = wr_valid_i & wr_ready_o;
  assign pop        = rd_en_i & ~empty_o;
  assign rd_data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      open_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      open_q   <= 1'b1;
    end
  end

  // NOTE: storage is deliberately left unreset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/axis_nway_adder.sv
// N-input AXI-Stream join-and-add: one beat per channel is summed into one full-precision beat.
// Each channel is buffered in its own FIFO; the join pops all heads together when the output can take a beat.
module axis_nway_adder
  import axis_nway_adder_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int SIGNED = 0,
  parameter int SUM_W  = sum_w_f(DATA_W, NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_data,
  input  logic [NUM_CH-1:0]        s_axis_valid,
  output logic [NUM_CH-1:0]        s_axis_ready,
  output logic [SUM_W-1:0]         m_axis_data,
  input  logic                     m_axis_ready,
  output logic                     m_axis_valid
);

  localparam int EXT_W = SUM_W - DATA_W;

  logic [NUM_CH-1:0] empty;
  logic [DATA_W-1:0] head [NUM_CH];
  logic              fire;
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    axis_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_valid_i (s_axis_valid[g]),
      .wr_ready_o (s_axis_ready[g]),
      .wr_data_i  (s_axis_data[g*DATA_W +: DATA_W]),
      .rd_en_i    (fire),
      .rd_data_o  (head[g]),
      .empty_o    (empty[g])
    );
  end

  // Join only when every channel has a head and the output register is free or draining.
  assign fire = ~|empty & (~m_valid_q | m_axis_ready);

  // Extend each head per SIGNED, then accumulate; SUM_W is wide enough that no carry is lost.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (SIGNED != 0) sum = sum + {{EXT_W{head[i][DATA_W-1]}}, head[i]};
      else             sum = sum + {{EXT_W{1'b0}}, head[i]};
    end
  end

  always_comb begin
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    if (fire) begin
      m_data_d  = sum;
      m_valid_d = 1'b1;
    end else if (m_valid_q && m_axis_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign m_axis_data  = m_data_q;
  assign m_axis_valid = m_valid_q;

endmodule

// File: tb/tb_axis_nway_adder.sv
// Directed bench for axis_nway_adder: NUM_CH=3, DATA_W=8, DEPTH=4, plus a SIGNED=1 copy.
// Inputs change and outputs are sampled on the falling edge; the design works on the rising edge.
module tb_axis_nway_adder;

  localparam int NUM_CH = 3;
  localparam int DATA_W = 8;
  localparam int SUM_W  = 10;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_CH*DATA_W-1:0] s_data = '0;
  logic [NUM_CH-1:0]        s_valid = '0;
  logic [NUM_CH-1:0]        s_valid_sg = '0;
  logic [NUM_CH-1:0]        s_ready, s_ready_sg;
  logic [SUM_W-1:0]         m_data, m_data_sg;
  logic                     m_valid, m_valid_sg;
  logic                     m_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [SUM_W-1:0] got_q[$];

  always #5 clk = ~clk;

  axis_nway_adder #(.NUM_CH(3), .DATA_W(8), .DEPTH(4), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_data(s_data), .s_axis_valid(s_valid), .s_axis_ready(s_ready),
    .m_axis_data(m_data), .m_axis_ready(m_ready), .m_axis_valid(m_valid)
  );

  axis_nway_adder #(.NUM_CH(3), .DATA_W(8), .DEPTH(4), .SIGNED(1)) u_dut_sg (
    .clk(clk), .rst_n(rst_n),
    .s_axis_data(s_data), .s_axis_valid(s_valid_sg), .s_axis_ready(s_ready_sg),
    .m_axis_data(m_data_sg), .m_axis_ready(m_ready), .m_axis_valid(m_valid_sg)
  );

  function automatic logic [23:0] pack3(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
    return {c, b, a};
  endfunction

  // Leaves the bench on a falling edge one rising edge after release.
  task automatic do_reset();
    s_valid    = '0;
    s_valid_sg = '0;
    m_ready    = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Accepts output beats with m_ready=1 until n are seen or the cycle budget runs out.
  task automatic collect(input int n, input int budget);
    got_q.delete();
    m_ready = 1'b1;
    for (int i = 0; i < budget && got_q.size() < n; i++) begin
      if (m_valid) got_q.push_back(m_data);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    s_valid = '0;
    rst_n   = 1'b0;
    #2;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %0b want 0", m_valid); end
    checks++; if (m_data !== 10'h000) begin errors++; $display("FAIL reset_m_data got %h want 000", m_data); end
    checks++; if (s_ready !== 3'b000) begin errors++; $display("FAIL reset_s_ready got %b want 000", s_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (s_ready !== 3'b000) begin errors++; $display("FAIL release_s_ready_early got %b want 000", s_ready); end
    @(negedge clk);
    checks++; if (s_ready !== 3'b111) begin errors++; $display("FAIL release_s_ready got %b want 111", s_ready); end
  endtask

  task automatic test_single_beat();
    do_reset();
    m_ready = 1'b1;
    s_data  = pack3(8'hFF, 8'hFF, 8'hFF);
    s_valid = 3'b111;
    @(negedge clk);
    s_valid = '0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %0b want 0", m_valid); end
    @(negedge clk);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", m_valid); end
    checks++; if (m_data !== 10'h2FD) begin errors++; $display("FAIL single_data got %h want 2fd", m_data); end
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_one_cycle got %0b want 0", m_valid); end
  endtask

  task automatic test_staggered();
    logic exp_valid;
    do_reset();
    m_ready = 1'b1;
    s_data  = pack3(8'd10, 8'd20, 8'd30);
    for (int c = 0; c < 10; c++) begin
      exp_valid = (c == 7);
      checks++; if (s_ready !== 3'b111) begin errors++; $display("FAIL stagger_ready c=%0d got %b want 111", c, s_ready); end
      checks++; if (m_valid !== exp_valid) begin errors++; $display("FAIL stagger_valid c=%0d got %0b want %0b", c, m_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (m_data !== 10'd60) begin errors++; $display("FAIL stagger_data got %0d want 60", m_data); end
      end
      s_valid = {c == 5, c == 3, c == 0};
      @(negedge clk);
    end
    s_valid = '0;
  endtask

  task automatic test_backpressure();
    logic exp_rdy;
    do_reset();
    m_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      exp_rdy = (k < 4);
      checks++; if (s_ready[0] !== exp_rdy) begin errors++; $display("FAIL bp_ready0 k=%0d got %0b want %0b", k, s_ready[0], exp_rdy); end
      s_data  = pack3((k < 4) ? 8'(10 * (k + 1)) : 8'd50, 8'd0, 8'd0);
      s_valid = 3'b001;
      @(negedge clk);
    end
    s_valid = '0;
    for (int k = 0; k < 4; k++) begin
      s_data  = pack3(8'd0, 8'(k + 1), 8'(k + 1));
      s_valid = 3'b110;
      @(negedge clk);
    end
    s_valid = '0;
    collect(4, 20);
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL bp_count got %0d want 4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      checks++; if (got_q[i] !== 10'(12 * (i + 1))) begin errors++; $display("FAIL bp_data i=%0d got %0d want %0d", i, got_q[i], 12 * (i + 1)); end
    end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_extra_beat got %0b want 0", m_valid); end
  endtask

  task automatic test_signed();
    do_reset();
    m_ready    = 1'b1;
    s_data     = pack3(8'h80, 8'h80, 8'h80);
    s_valid    = 3'b111;
    s_valid_sg = 3'b111;
    @(negedge clk);
    s_valid    = '0;
    s_valid_sg = '0;
    @(negedge clk);
    checks++; if (m_valid_sg !== 1'b1) begin errors++; $display("FAIL signed_valid got %0b want 1", m_valid_sg); end
    checks++; if (m_data_sg !== 10'h280) begin errors++; $display("FAIL signed_data got %h want 280", m_data_sg); end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL unsigned_valid got %0b want 1", m_valid); end
    checks++; if (m_data !== 10'h180) begin errors++; $display("FAIL unsigned_data got %h want 180", m_data); end
    @(negedge clk);
  endtask

  task automatic test_output_stall();
    int   accepted;
    int   occ;
    logic exp_rdy;
    do_reset();
    m_ready  = 1'b0;
    accepted = 0;
    for (int c = 0; c < 9; c++) begin
      occ     = accepted - ((c >= 2) ? 1 : 0);
      exp_rdy = (occ < 4);
      checks++; if (s_ready !== {3{exp_rdy}}) begin errors++; $display("FAIL stall_ready c=%0d got %b want %b", c, s_ready, {3{exp_rdy}}); end
      if (c >= 2) begin
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL stall_valid c=%0d got %0b want 1", c, m_valid); end
        checks++; if (m_data !== 10'd3) begin errors++; $display("FAIL stall_data c=%0d got %0d want 3", c, m_data); end
      end
      s_data  = pack3(8'(accepted + 1), 8'(accepted + 1), 8'(accepted + 1));
      s_valid = 3'b111;
      if (exp_rdy) accepted++;
      @(negedge clk);
    end
    s_valid = '0;
    collect(5, 30);
    checks++; if (got_q.size() != 5) begin errors++; $display("FAIL stall_count got %0d want 5", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 5; i++) begin
      checks++; if (got_q[i] !== 10'(3 * (i + 1))) begin errors++; $display("FAIL stall_drain i=%0d got %0d want %0d", i, got_q[i], 3 * (i + 1)); end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_valid;
    do_reset();
    m_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      exp_valid = (c >= 2 && c <= 5);
      checks++; if (m_valid !== exp_valid) begin errors++; $display("FAIL b2b_valid c=%0d got %0b want %0b", c, m_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (m_data !== 10'(6 * (c - 1))) begin errors++; $display("FAIL b2b_data c=%0d got %0d want %0d", c, m_data, 6 * (c - 1)); end
      end
      if (c < 4) begin
        s_data  = pack3(8'(c + 1), 8'(2 * (c + 1)), 8'(3 * (c + 1)));
        s_valid = 3'b111;
      end else begin
        s_valid = '0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    m_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      s_data  = pack3(8'(c + 1), 8'(c + 1), 8'(c + 1));
      s_valid = 3'b111;
      @(negedge clk);
    end
    s_valid = '0;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL mid_pending got %0b want 1", m_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got %0b want 0", m_valid); end
    checks++; if (m_data !== 10'd0) begin errors++; $display("FAIL mid_async_data got %0d want 0", m_data); end
    checks++; if (s_ready !== 3'b000) begin errors++; $display("FAIL mid_async_ready got %b want 000", s_ready); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (s_ready !== 3'b111) begin errors++; $display("FAIL mid_release_ready got %b want 111", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_valid got %0b want 0", m_valid); end
    m_ready = 1'b1;
    s_data  = pack3(8'd7, 8'd8, 8'd9);
    s_valid = 3'b111;
    @(negedge clk);
    s_valid = '0;
    @(negedge clk);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL mid_post_valid got %0b want 1", m_valid); end
    checks++; if (m_data !== 10'd24) begin errors++; $display("FAIL mid_post_data got %0d want 24", m_data); end
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_post_extra got %0b want 0", m_valid); end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_staggered();
    test_backpressure();
    test_signed();
    test_output_stall();
    test_back_to_back();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

endmodule
